// File: rtl/adder_seq_pkg.sv
// Shared definitions for the sequential 32-bit adder controller.
//   state_t : controller FSM encoding (IDLE/LO/HI/DONE)
//   HALF_W  : adder slice width, FULL_W : operand width
//   REQ0/1  : requester identifiers carried on rsp_id
package adder_seq_pkg;

  localparam int HALF_W = 16;
  localparam int FULL_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/adder_16bit.sv
// 16-bit ripple slice shared by the sequential controller.
//   a, b : addends      cin  : carry in
//   sum  : a+b+cin      cout : carry out of bit 15
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};

endmodule

// File: rtl/adder_32bit_seq_ctrl.sv
// Two-requester controller computing 32-bit a+b+cin on one 16-bit slice,
// low half first, then high half.
//   clk, rst                     : clock, synchronous active-high reset
//   reqN_valid/ready/a/b/cin     : requester N operation handshake (N=0,1)
//   rsp_valid/ready              : result handshake
//   rsp_sum, rsp_cout, rsp_id    : 32-bit sum, carry out, issuing requester
// ARB_RR=1 round-robin, ARB_RR=0 fixed priority with req0 winning.
module adder_32bit_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int ARB_RR = 1,
  parameter int HALF_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [2*HALF_W-1:0]   req0_a,
  input  logic [2*HALF_W-1:0]   req0_b,
  input  logic                  req0_cin,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [2*HALF_W-1:0]   req1_a,
  input  logic [2*HALF_W-1:0]   req1_b,
  input  logic                  req1_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*HALF_W-1:0]   rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_id
);

  localparam int W = 2 * HALF_W;

  state_t            state;
  logic [W-1:0]      a_reg, b_reg;
  logic              cin_reg;
  logic              c16;
  logic              last_grant;
  logic              gnt_id;
  logic              accept;
  logic [HALF_W-1:0] add_a, add_b, add_sum;
  logic              add_cin, add_cout;

  // Grant is purely combinational so the winner sees ready in the same
  // cycle its valid is presented.
  always_comb begin
    if (ARB_RR != 0)
      gnt_id = (req0_valid && req1_valid) ? ~last_grant
                                          : (req1_valid ? REQ1 : REQ0);
    else
      gnt_id = req0_valid ? REQ0 : REQ1;
    accept = (state == IDLE) && !rst && (req0_valid || req1_valid);
  end

  assign req0_ready = accept && (gnt_id == REQ0);
  assign req1_ready = accept && (gnt_id == REQ1);

  // Slice inputs are held at zero outside the two add passes.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      LO: begin
        add_a   = a_reg[HALF_W-1:0];
        add_b   = b_reg[HALF_W-1:0];
        add_cin = cin_reg;
      end
      HI: begin
        add_a   = a_reg[W-1:HALF_W];
        add_b   = b_reg[W-1:HALF_W];
        add_cin = c16;
      end
      default: ;
    endcase
  end

  adder_16bit u_slice (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // rsp_id is captured at accept and rsp_sum is built in place; both are
  // only meaningful once rsp_valid rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= REQ0;
      last_grant <= REQ1;
      c16        <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      cin_reg    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_reg      <= (gnt_id == REQ1) ? req1_a   : req0_a;
          b_reg      <= (gnt_id == REQ1) ? req1_b   : req0_b;
          cin_reg    <= (gnt_id == REQ1) ? req1_cin : req0_cin;
          rsp_id     <= gnt_id;
          last_grant <= gnt_id;
          state      <= LO;
        end
        LO: begin
          rsp_sum[HALF_W-1:0] <= add_sum;
          c16                 <= add_cout;
          state               <= HI;
        end
        HI: begin
          rsp_sum[W-1:HALF_W] <= add_sum;
          rsp_cout            <= add_cout;
          rsp_valid           <= 1'b1;
          state               <= DONE;
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_32bit_seq_ctrl.sv
// Scoreboard bench: instance 0 round-robin, instance 1 fixed priority.
// A per-instance driver models arbitration/occupancy and pushes expected
// results at accept; a monitor pops and checks at each rsp handshake.
module tb_adder_32bit_seq_ctrl;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        id;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      2:       return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int RR = (g == 0) ? 1 : 0;

    logic        rst_i, v0, v1, cin0, cin1, rspr;
    logic [31:0] a0, b0, a1, b1, rsum;
    logic        rdy0, rdy1, rv, rcout, rid;

    exp_t q[$];
    int   cyc_n   = 0;
    int   hs_cnt  = 0;
    int   hs_used = 0;
    int   acc_cnt = 0;
    int   refresh = 0;
    bit   idle    = 1'b1;
    bit   lg      = 1'b1;
    bit   fin     = 1'b0;

    adder_32bit_seq_ctrl #(.ARB_RR(RR), .HALF_W(16)) dut (
      .clk        (clk),
      .rst        (rst_i),
      .req0_valid (v0),
      .req0_ready (rdy0),
      .req0_a     (a0),
      .req0_b     (b0),
      .req0_cin   (cin0),
      .req1_valid (v1),
      .req1_ready (rdy1),
      .req1_a     (a1),
      .req1_b     (b1),
      .req1_cin   (cin1),
      .rsp_valid  (rv),
      .rsp_ready  (rspr),
      .rsp_sum    (rsum),
      .rsp_cout   (rcout),
      .rsp_id     (rid)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s inst%0d cyc%0d: got %h want %h", name, g, cyc_n, act, exp);
      end
    endtask

    initial forever begin
      @(posedge clk);
      cyc_n++;
    end

    // Monitor: latency on rise, stability while stalled, value on handshake.
    initial begin
      bit          prev_v = 1'b0, prev_r = 1'b0;
      logic [33:0] held = '0;
      forever begin
        @(negedge clk);
        if (rst_i) begin
          prev_v = 1'b0;
        end else begin
          if (rv) begin
            if (q.size() == 0) begin
              vectors++;
              errors++;
              $display("FAIL unexpected_rsp inst%0d cyc%0d: got sum %h with nothing outstanding", g, cyc_n, rsum);
            end else begin
              if (!prev_v) chk("latency", 64'(cyc_n - q[0].t), 64'd3);
              if (prev_v && !prev_r) chk("hold", {rid, rcout, rsum}, held);
              if (rspr) begin
                chk("rsp", {rid, rcout, rsum}, {q[0].id, q[0].cout, q[0].sum});
                void'(q.pop_front());
                hs_cnt++;
              end
            end
          end
          prev_v = rv;
          prev_r = rspr;
          held   = {rid, rcout, rsum};
        end
      end
    end

    // One clock of stimulus: check readies against the model at negedge,
    // then update requester inputs just after the rising edge.
    task automatic cyc();
      bit          acc, gid;
      logic [32:0] full;
      @(negedge clk);
      acc = !rst_i && idle && (v0 || v1);
      if (RR != 0) gid = (v0 && v1) ? !lg : v1;
      else         gid = !v0;
      chk("ready", {rdy1, rdy0}, {acc && gid, acc && !gid});
      if (acc) begin
        full = gid ? ({1'b0, a1} + {1'b0, b1} + {32'b0, cin1})
                   : ({1'b0, a0} + {1'b0, b0} + {32'b0, cin0});
        q.push_back('{sum: full[31:0], cout: full[32], id: gid, t: cyc_n});
        lg   = gid;
        idle = 1'b0;
        acc_cnt++;
      end
      @(posedge clk);
      #1;
      if (hs_cnt != hs_used) begin
        hs_used = hs_cnt;
        idle    = 1'b1;
      end
      if (acc) begin
        if (gid) begin
          v1 = (refresh == 0) ? 1'b0 : (refresh == 1) ? 1'b1 : 1'($urandom_range(0, 1));
          a1 = pick(); b1 = pick(); cin1 = 1'($urandom_range(0, 1));
        end else begin
          v0 = (refresh == 0) ? 1'b0 : (refresh == 1) ? 1'b1 : 1'($urandom_range(0, 1));
          a0 = pick(); b0 = pick(); cin0 = 1'($urandom_range(0, 1));
        end
      end
      if (refresh == 2) begin
        rspr = ($urandom_range(0, 3) != 0);
        if (!v0 && $urandom_range(0, 2) == 0) begin
          v0 = 1'b1; a0 = pick(); b0 = pick(); cin0 = 1'($urandom_range(0, 1));
        end
        if (!v1 && $urandom_range(0, 2) == 0) begin
          v1 = 1'b1; a1 = pick(); b1 = pick(); cin1 = 1'($urandom_range(0, 1));
        end
      end
    endtask

    task automatic set_req(input bit id, input logic [31:0] a, input logic [31:0] b, input bit c);
      if (id) begin v1 = 1'b1; a1 = a; b1 = b; cin1 = c; end
      else    begin v0 = 1'b1; a0 = a; b0 = b; cin0 = c; end
    endtask

    task automatic wait_acc(input int n);
      int target = acc_cnt + n;
      int k = 0;
      while (acc_cnt < target && k < 40 * n) begin cyc(); k++; end
      if (acc_cnt < target) begin
        vectors++;
        errors++;
        $display("FAIL accept_timeout inst%0d: got %0d accepts want %0d", g, acc_cnt, target);
      end
    endtask

    task automatic drain();
      int k = 0;
      while (!(idle && q.size() == 0 && !v0 && !v1) && k < 200) begin cyc(); k++; end
      if (k >= 200) begin
        vectors++;
        errors++;
        $display("FAIL drain_timeout inst%0d: got %0d outstanding want 0", g, q.size());
      end
    endtask

    task automatic do_reset(input int n);
      rst_i = 1'b1;
      q.delete();
      repeat (n) cyc();
      rst_i   = 1'b0;
      idle    = 1'b1;
      lg      = 1'b1;
      hs_used = hs_cnt;
      chk("reset_state", {rv, rcout, rid, rsum}, 64'd0);
    endtask

    initial begin
      rst_i = 1'b1; rspr = 1'b1;
      v0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
      v1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      @(posedge clk);
      #1;
      do_reset(2);

      // carry across the halves, then full wrap with carry-in
      set_req(1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0); wait_acc(1); drain();
      set_req(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1); wait_acc(1); drain();

      // both requesters continuously valid
      refresh = 1;
      set_req(1'b0, 32'h0101_0101, 32'h1020_3040, 1'b0);
      set_req(1'b1, 32'hA0A0_A0A0, 32'h0B0B_0B0B, 1'b1);
      wait_acc(4);
      refresh = 0;
      drain();

      // consumer stall in DONE with the other requester waiting
      rspr = 1'b0;
      set_req(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
      wait_acc(1);
      set_req(1'b1, pick(), pick(), 1'b0);
      repeat (8) cyc();
      rspr = 1'b1;
      drain();

      // reset while the high half is being added
      set_req(1'b0, 32'hDEAD_BEEF, 32'h0123_4567, 1'b1);
      wait_acc(1);
      cyc();
      do_reset(1);
      repeat (4) cyc();
      set_req(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0); wait_acc(1); drain();

      // random traffic with random backpressure
      refresh = 2;
      repeat (400) cyc();
      refresh = 0;
      rspr    = 1'b1;
      drain();
      fin = 1'b1;
    end
  end

  initial begin
    int k = 0;
    while (!(g_dut[0].fin && g_dut[1].fin) && k < 20000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 20000) begin
      vectors++;
      errors++;
      $display("FAIL global_timeout: got %0d cycles want completion", k);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
